echo_indication_input: RTL and testbench

Receive side of the Echo indication pipe: accepts 96-bit serialized messages from the transport pipe, decodes the tag, and replays each valid message as a `heard(meth, v)` method call toward the software-facing indication interface. It is the inverse of the indication output serializer. A two-slot ping-pong buffer decouples pipe arrival from downstream readiness. Messages with unknown tags are dropped and counted.

---
 rtl/echo_pipe_pkg.sv | 44 ++++
 rtl/echo_pingpong_buf.sv | 68 ++++++
 rtl/echo_indication_input.sv | 106 ++++++++++
 tb/tb_echo_indication_input.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pipe_pkg.sv
// echo_pipe_pkg
// Shared definitions for the Echo indication pipe: the 96-bit message layout
// (tag, meth and v fields), the tag value of a `heard` message, and the
// argument bundle replayed toward the indication interface.

package echo_pipe_pkg;

    // Field placement inside the serialized message
    localparam int TAG_LSB  = 0;
    localparam int TAG_W    = 32;
    localparam int METH_LSB = 32;
    localparam int METH_W   = 32;
    localparam int V_LSB    = 64;
    localparam int V_W      = 32;
    localparam int MSG_W    = TAG_W + METH_W + V_W;

    // Tag carried by a `heard(meth, v)` message
    localparam logic [TAG_W-1:0] TAG_HEARD = 32'd1;

    // Serialized message; the first member lands in the most significant bits
    typedef struct packed {
        logic [V_W-1:0]    v;
        logic [METH_W-1:0] meth;
        logic [TAG_W-1:0]  tag;
    } echo_msg_t;

    // Arguments of one `heard` call, as held in the buffer
    typedef struct packed {
        logic [METH_W-1:0] meth;
        logic [V_W-1:0]    v;
    } heard_args_t;

    localparam int HEARD_ARGS_W = $bits(heard_args_t);

    // Split a raw pipe word into its named fields
    function automatic echo_msg_t unpack_msg(input logic [MSG_W-1:0] raw);
        echo_msg_t m;
        m.tag  = raw[TAG_LSB  +: TAG_W];
        m.meth = raw[METH_LSB +: METH_W];
        m.v    = raw[V_LSB    +: V_W];
        return m;
    endfunction

endpackage

// File: rtl/echo_pingpong_buf.sv
// echo_pingpong_buf
// Two-slot ping-pong buffer with strict FIFO order. The writer fills the slot
// under wr_sel and the reader drains the slot under rd_sel; both pointers
// toggle on every completed transfer, so a push and a pop in the same cycle
// always address different slots.

module echo_pingpong_buf #(
    parameter int W = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    logic [1:0]   valid;
    logic         wr_sel;
    logic         rd_sel;
    logic [W-1:0] slot_data [2];

    logic         do_push;
    logic         do_pop;

    // The pointers keep the occupied slots contiguous starting at rd_sel, so
    // the slot under wr_sel is busy only when both are, and the slot under
    // rd_sel is idle only when neither is.
    assign full     = valid[wr_sel];
    assign empty    = !valid[rd_sel];
    assign pop_data = slot_data[rd_sel];

    // Requests against a full or empty buffer are ignored
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Slot occupancy and the two pointers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid  <= 2'b00;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (do_push) begin
                valid[wr_sel] <= 1'b1;
                wr_sel        <= ~wr_sel;
            end
            if (do_pop) begin
                valid[rd_sel] <= 1'b0;
                rd_sel        <= ~rd_sel;
            end
        end
    end

    // Payload storage
    // NOTE: the payload array has no reset; its contents are only observed
    // through a slot whose valid bit is set, and valid is reset.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            slot_data[wr_sel] <= push_data;
        end
    end

endmodule

// File: rtl/echo_indication_input.sv
// echo_indication_input
// Receive side of the Echo indication pipe. Accepts 96-bit messages from the
// transport pipe, keeps those tagged as `heard` in a two-slot ping-pong
// buffer and replays them in order as heard(meth, v) calls. Messages with any
// other tag are dropped and counted in a saturating counter.
//
// Build option: define ECHO_INDICATION_INPUT_BYPASS_EN to let a `heard`
// message arriving at an empty buffer fire in the same cycle, straight from
// the pipe (adds a combinational pipe-to-indication path).

module echo_indication_input #(
    parameter logic [31:0] TAG_HEARD = echo_pipe_pkg::TAG_HEARD,
    parameter int          CNT_W     = 16
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              pipe_enq__ENA,
    input  logic [echo_pipe_pkg::MSG_W-1:0]   pipe_enq_v,
    output logic                              pipe_enq__RDY,
    output logic                              indication_heard__ENA,
    output logic [echo_pipe_pkg::METH_W-1:0]  indication_heard_meth,
    output logic [echo_pipe_pkg::V_W-1:0]     indication_heard_v,
    input  logic                              indication_heard__RDY,
    output logic [CNT_W-1:0]                  drop_count
);

    import echo_pipe_pkg::*;

    echo_msg_t   msg;
    heard_args_t in_args;
    heard_args_t buf_args;
    heard_args_t out_args;

    logic accept;
    logic tag_ok;
    logic good_accept;
    logic bad_accept;
    logic bypass;
    logic buf_push;
    logic buf_pop;
    logic buf_full;
    logic buf_empty;

    assign msg          = unpack_msg(pipe_enq_v);
    assign in_args.meth = msg.meth;
    assign in_args.v    = msg.v;

    // Ready depends only on registered occupancy and reset, never on the
    // downstream ready, so no combinational loop can form through the pipe.
    assign pipe_enq__RDY = !buf_full && !RST;

    assign accept      = pipe_enq__ENA && pipe_enq__RDY;
    assign tag_ok      = (msg.tag == TAG_HEARD);
    assign good_accept = accept && tag_ok;
    assign bad_accept  = accept && !tag_ok;

`ifdef ECHO_INDICATION_INPUT_BYPASS_EN
    // An empty buffer with a ready consumer lets the message skip storage
    assign bypass = good_accept && buf_empty && indication_heard__RDY;
`else
    assign bypass = 1'b0;
`endif

    assign buf_push = good_accept && !bypass;
    assign buf_pop  = !buf_empty && indication_heard__RDY;

    echo_pingpong_buf #(
        .W (HEARD_ARGS_W)
    ) u_buf (
        .CLK       (CLK),
        .RST       (RST),
        .push      (buf_push),
        .push_data (in_args),
        .pop       (buf_pop),
        .pop_data  (buf_args),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign indication_heard__ENA = buf_pop || bypass;

    // Select the call arguments; they read as zero whenever no call fires
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        out_args = '0;
        if (bypass) begin
            out_args = in_args;
        end else if (buf_pop) begin
            out_args = buf_args;
        end
    end

    assign indication_heard_meth = out_args.meth;
    assign indication_heard_v    = out_args.v;

    // Saturating count of messages dropped for an unknown tag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            drop_count <= '0;
        end else if (bad_accept && (drop_count != {CNT_W{1'b1}})) begin
            drop_count <= drop_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_echo_indication_input.sv
// tb_echo_indication_input
// Randomized and directed stimulus with a queue-based scoreboard. The driver
// pushes the expected heard(meth, v) of every accepted good message; an
// independent monitor pops and compares whenever the DUT fires a call.

module tb_echo_indication_input;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

`ifdef ECHO_INDICATION_INPUT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             enq_ena = 1'b0;
    logic [95:0]      enq_data = '0;
    logic             enq_rdy;
    logic             heard_ena;
    logic [31:0]      heard_meth;
    logic [31:0]      heard_v;
    logic             heard_rdy = 1'b0;
    logic [CNT_W-1:0] drop_count;

    typedef struct {
        logic [31:0] meth;
        logic [31:0] v;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   model_drop = 0;
    int   delivered = 0;
    exp_t e;

    echo_indication_input #(
        .TAG_HEARD (32'd1),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .pipe_enq__ENA         (enq_ena),
        .pipe_enq_v            (enq_data),
        .pipe_enq__RDY         (enq_rdy),
        .indication_heard__ENA (heard_ena),
        .indication_heard_meth (heard_meth),
        .indication_heard_v    (heard_v),
        .indication_heard__RDY (heard_rdy),
        .drop_count            (drop_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] mk(input logic [31:0] tag, input logic [31:0] meth,
                                       input logic [31:0] v);
        return {v, meth, tag};
    endfunction

    // One clock cycle of stimulus, entered and left at posedge+1. The
    // reference keeps accepted-but-undelivered calls in q, so the block can
    // take a message exactly when fewer than two are outstanding.
    task automatic cycle(input bit ena, input logic [95:0] data, input bit hrdy, output bit acc);
        bit   model_rdy;
        exp_t n;
        enq_ena   = ena;
        enq_data  = data;
        heard_rdy = hrdy;
        #1;
        model_rdy = (q.size() < 2);
        check("enq_rdy", {63'd0, enq_rdy}, {63'd0, model_rdy});
        check("drop_count", 64'(drop_count), 64'(model_drop));
        acc = ena && model_rdy;
        if (acc) begin
            if (data[31:0] == 32'd1) begin
                n.meth = data[63:32];
                n.v    = data[95:64];
                n.cyc  = cyc;
                q.push_back(n);
            end else if (model_drop < CNT_MAX) begin
                model_drop++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // Monitor: mid-cycle, decide whether a call is due and compare it
    always @(negedge CLK) begin
        if (!RST) begin
            if (heard_rdy && q.size() > 0 && (BYP || q[0].cyc < cyc)) begin
                check("heard_ena", {63'd0, heard_ena}, 64'd1);
                if (heard_ena) begin
                    e = q.pop_front();
                    check("heard_args", {heard_meth, heard_v}, {e.meth, e.v});
                    delivered++;
                end
            end else begin
                check("heard_ena", {63'd0, heard_ena}, 64'd0);
                check("idle_args", {heard_meth, heard_v}, 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int d0;

        // Reset values, with the consumer ready
        heard_rdy = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_enq_rdy", {63'd0, enq_rdy}, 64'd0);
        check("rst_heard_ena", {63'd0, heard_ena}, 64'd0);
        check("rst_args", {heard_meth, heard_v}, 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        RST = 1'b0;

        // Single message; ready must already be high in the first cycle
        d0 = delivered;
        cycle(1'b1, mk(32'd1, 32'h5, 32'hDEADBEEF), 1'b1, acc);
        check("first_accept", {63'd0, acc}, 64'd1);
        cycle(1'b0, '0, 1'b1, acc);
        check("first_delivered", 64'(delivered - d0), 64'd1);

        // Backpressure: two accepted, third refused until the consumer drains
        cycle(1'b1, mk(32'd1, 32'h11, 32'hA1), 1'b0, acc);
        cycle(1'b1, mk(32'd1, 32'h12, 32'hA2), 1'b0, acc);
        repeat (2) begin
            cycle(1'b1, mk(32'd1, 32'h13, 32'hA3), 1'b0, acc);
            check("full_reject", {63'd0, acc}, 64'd0);
        end
        acc = 1'b0;
        for (int i = 0; i < 5 && !acc; i++) begin
            cycle(1'b1, mk(32'd1, 32'h13, 32'hA3), 1'b1, acc);
        end
        check("third_accept", {63'd0, acc}, 64'd1);
        repeat (3) cycle(1'b0, '0, 1'b1, acc);

        // Bad tag followed by a good one
        cycle(1'b1, mk(32'd7, 32'h8, 32'h0), 1'b1, acc);
        cycle(1'b1, mk(32'd1, 32'h9, 32'hC0FFEE), 1'b1, acc);
        repeat (2) cycle(1'b0, '0, 1'b1, acc);
        check("drop_after_bad", 64'(drop_count), 64'd1);

        // Eight back-to-back messages at full rate
        d0 = delivered;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, mk(32'd1, 32'h100 + 32'(i), $urandom), 1'b1, acc);
            check("b2b_accept", {63'd0, acc}, 64'd1);
        end
        repeat (2) cycle(1'b0, '0, 1'b1, acc);
        check("b2b_delivered", 64'(delivered - d0), 64'd8);

        // Twenty bad tags saturate the counter
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, mk(32'd2 + 32'(i), $urandom, $urandom), 1'b1, acc);
        end
        cycle(1'b0, '0, 1'b1, acc);
        check("drop_saturated", 64'(drop_count), 64'(CNT_MAX));

        // Randomized traffic and backpressure
        for (int i = 0; i < 300; i++) begin
            logic [31:0] tag;
            tag = ($urandom_range(0, 4) == 0) ? 32'd2 + $urandom_range(0, 1000) : 32'd1;
            cycle($urandom_range(0, 3) != 0, mk(tag, $urandom, $urandom),
                  $urandom_range(0, 9) < 7, acc);
        end

        // Fill both slots, then reset asynchronously mid-cycle
        for (int i = 0; i < 10 && q.size() > 0; i++) cycle(1'b0, '0, 1'b1, acc);
        cycle(1'b1, mk(32'd1, 32'h21, 32'hB1), 1'b0, acc);
        cycle(1'b1, mk(32'd1, 32'h22, 32'hB2), 1'b0, acc);
        check("fill_count", 64'(q.size()), 64'd2);
        enq_ena   = 1'b0;
        heard_rdy = 1'b1;
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_enq_rdy", {63'd0, enq_rdy}, 64'd0);
        check("mid_rst_heard_ena", {63'd0, heard_ena}, 64'd0);
        check("mid_rst_args", {heard_meth, heard_v}, 64'd0);
        check("mid_rst_drop", 64'(drop_count), 64'd0);
        q.delete();
        model_drop = 0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) cycle(1'b0, '0, 1'b1, acc);
        cycle(1'b1, mk(32'd1, 32'h31, 32'hC1), 1'b1, acc);
        check("post_rst_accept", {63'd0, acc}, 64'd1);

        // Drain whatever is still outstanding
        for (int i = 0; i < 10 && q.size() > 0; i++) cycle(1'b0, '0, 1'b1, acc);
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
